// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the mini CPU: opcodes, instruction field positions and fetch states.
package cpu_isa_pkg;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS_MSB  = 1;
  localparam int unsigned RS_LSB  = 0;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StHalted = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] imm;
  } dec_t;

  // Pure field split; rs and imm are extracted for every opcode.
  function automatic dec_t decode(input logic [7:0] instr);
    dec_t d;
    d.op  = instr[OP_MSB:OP_LSB];
    d.rd  = instr[RD_MSB:RD_LSB];
    d.rs  = instr[RS_MSB:RS_LSB];
    d.imm = instr[IMM_MSB:IMM_LSB];
    return d;
  endfunction

  function automatic logic is_alu(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Fetch/decode sequencer: walks the PC, splits instructions and hands them over valid/ready.
// Optional retired-instruction counter enabled by defining FETCH_PERF_EN.
module fetch_decode
  import cpu_isa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] pc,
  input  logic [7:0] instr,
  output logic       dec_valid,
  input  logic       dec_ready,
  output logic [1:0] dec_op,
  output logic [1:0] dec_rd,
  output logic [1:0] dec_rs,
  output logic [3:0] dec_imm,
  output logic       busy,
`ifdef FETCH_PERF_EN
  output logic       halted,
  output logic [7:0] retired_cnt
`else
  output logic       halted
`endif
);

  fetch_state_e state_q, state_d;
  logic [3:0]   pc_q, pc_d;
  logic         valid_q, valid_d;
  dec_t         dec_q, dec_d;
  dec_t         fetched;
  logic         load;
  logic         start_accept;

  assign fetched      = decode(instr);
  assign load         = (state_q == StRun) && (!valid_q || dec_ready);
  assign start_accept = start && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    dec_d   = dec_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          state_d = StRun;
          pc_d    = 4'd0;
          valid_d = 1'b0;
        end
      end
      StRun: begin
        if (load) begin
          if (fetched.op == OP_HALT) begin
            // Held instruction (if any) is accepted this cycle; PC parks on the HALT.
            state_d = StHalted;
            valid_d = 1'b0;
          end else begin
            dec_d   = fetched;
            valid_d = 1'b1;
            pc_d    = pc_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= 4'd0;
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      dec_q   <= dec_d;
    end
  end

  assign pc        = pc_q;
  assign dec_valid = valid_q;
  assign dec_op    = dec_q.op;
  assign dec_rd    = dec_q.rd;
  assign dec_rs    = dec_q.rs;
  assign dec_imm   = dec_q.imm;
  assign busy      = (state_q == StRun);
  assign halted    = (state_q == StHalted);

`ifdef FETCH_PERF_EN
  logic [7:0] retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 8'd0;
    end else if (start_accept) begin
      retired_q <= 8'd0;
    end else if (valid_q && dec_ready) begin
      retired_q <= retired_q + 8'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with a combinational instruction memory model.
module tb_fetch_decode;
  import cpu_isa_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       dec_valid;
  logic       dec_ready;
  logic [1:0] dec_op;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic [3:0] dec_imm;
  logic       busy;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [7:0] retired_cnt;
`endif

  logic [7:0] mem [16];
  int tests;
  int fails;

  assign instr = mem[pc];

  fetch_decode dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc          (pc),
    .instr       (instr),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_op      (dec_op),
    .dec_rd      (dec_rd),
    .dec_rs      (dec_rs),
    .dec_imm     (dec_imm),
    .busy        (busy),
`ifdef FETCH_PERF_EN
    .halted      (halted),
    .retired_cnt (retired_cnt)
`else
    .halted      (halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_pc;
    logic [3:0] exp_imm;
    logic [1:0] exp_rd;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
    mem[0] = 8'h15;
    mem[1] = 8'h23;
    mem[2] = 8'h71;
    mem[3] = 8'hC0;

    #12;
    chk("rst_pc", 16'(pc), 16'h0);
    chk("rst_valid", 16'(dec_valid), 16'h0);
    chk("rst_op", 16'(dec_op), 16'h0);
    chk("rst_rd", 16'(dec_rd), 16'h0);
    chk("rst_rs", 16'(dec_rs), 16'h0);
    chk("rst_imm", 16'(dec_imm), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
`ifdef FETCH_PERF_EN
    chk("rst_cnt", 16'(retired_cnt), 16'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Program run with ready held high
    pulse_start();
    chk("t1_busy", 16'(busy), 16'h1);
    chk("t1_pc0", 16'(pc), 16'h0);
    chk("t1_valid0", 16'(dec_valid), 16'h0);
    step();
    chk("t1_i0_valid", 16'(dec_valid), 16'h1);
    chk("t1_i0_op", 16'(dec_op), 16'(OP_MOV));
    chk("t1_i0_rd", 16'(dec_rd), 16'h1);
    chk("t1_i0_imm", 16'(dec_imm), 16'h5);
    chk("t1_i0_rs", 16'(dec_rs), 16'h1);
    chk("t1_i0_pc", 16'(pc), 16'h1);
    step();
    chk("t1_i1_op", 16'(dec_op), 16'(OP_MOV));
    chk("t1_i1_rd", 16'(dec_rd), 16'h2);
    chk("t1_i1_imm", 16'(dec_imm), 16'h3);
    chk("t1_i1_rs", 16'(dec_rs), 16'h3);
    chk("t1_i1_pc", 16'(pc), 16'h2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_i2_valid", 16'(dec_valid), 16'h1);
    chk("t1_i2_op", 16'(dec_op), 16'(OP_ADD));
    chk("t1_i2_rd", 16'(dec_rd), 16'h3);
    chk("t1_i2_rs", 16'(dec_rs), 16'h1);
    chk("t1_i2_pc", 16'(pc), 16'h3);
    step();
    chk("t1_h_valid", 16'(dec_valid), 16'h0);
    chk("t1_h_halted", 16'(halted), 16'h1);
    chk("t1_h_busy", 16'(busy), 16'h0);
    chk("t1_h_pc", 16'(pc), 16'h3);
`ifdef FETCH_PERF_EN
    chk("t1_cnt", 16'(retired_cnt), 16'h3);
`endif
    step();
    chk("t1_h2_halted", 16'(halted), 16'h1);
    chk("t1_h2_pc", 16'(pc), 16'h3);
    chk("t1_h2_valid", 16'(dec_valid), 16'h0);

    // Restart from HALTED with a 3-cycle stall on the first output
    dec_ready = 1'b0;
    pulse_start();
    chk("t2_pc0", 16'(pc), 16'h0);
    chk("t2_busy", 16'(busy), 16'h1);
    chk("t2_halted", 16'(halted), 16'h0);
`ifdef FETCH_PERF_EN
    chk("t2_cnt_clr", 16'(retired_cnt), 16'h0);
`endif
    step();
    chk("t2_i0_valid", 16'(dec_valid), 16'h1);
    chk("t2_i0_imm", 16'(dec_imm), 16'h5);
    chk("t2_i0_pc", 16'(pc), 16'h1);
    for (int s = 0; s < 3; s++) begin
      step();
      chk("t2_stall_valid", 16'(dec_valid), 16'h1);
      chk("t2_stall_rd", 16'(dec_rd), 16'h1);
      chk("t2_stall_imm", 16'(dec_imm), 16'h5);
      chk("t2_stall_pc", 16'(pc), 16'h1);
    end
    dec_ready = 1'b1;
    step();
    chk("t2_i1_rd", 16'(dec_rd), 16'h2);
    chk("t2_i1_imm", 16'(dec_imm), 16'h3);
    chk("t2_i1_pc", 16'(pc), 16'h2);
    step();
    chk("t2_i2_op", 16'(dec_op), 16'(OP_ADD));
    chk("t2_i2_pc", 16'(pc), 16'h3);
    step();
    chk("t2_h_halted", 16'(halted), 16'h1);
    chk("t2_h_valid", 16'(dec_valid), 16'h0);
    chk("t2_h_pc", 16'(pc), 16'h3);
`ifdef FETCH_PERF_EN
    chk("t2_cnt", 16'(retired_cnt), 16'h3);
`endif

    // 16 MOV words: PC wraps and address 0 is re-emitted without a bubble
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      mem[i] = {2'b00, a[1:0], a};
    end
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      step();
      exp_imm = 4'(k % 16);
      exp_rd  = 2'(k % 4);
      exp_pc  = 4'((k + 1) % 16);
      chk("t3_valid", 16'(dec_valid), 16'h1);
      chk("t3_imm", 16'(dec_imm), 16'(exp_imm));
      chk("t3_rd", 16'(dec_rd), 16'(exp_rd));
      chk("t3_pc", 16'(pc), 16'(exp_pc));
    end

    // Asynchronous reset while an instruction is held
    #2;
    rst = 1'b1;
    #1;
    chk("t4_valid", 16'(dec_valid), 16'h0);
    chk("t4_pc", 16'(pc), 16'h0);
    chk("t4_busy", 16'(busy), 16'h0);
    chk("t4_halted", 16'(halted), 16'h0);
    chk("t4_imm", 16'(dec_imm), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("t4_idle_busy", 16'(busy), 16'h0);
    chk("t4_idle_pc", 16'(pc), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
